// File: rtl/block_normalizer_pkg.sv
// Block-normalizer local types and derived widths.
package block_normalizer_pkg;

    import fp_pkg::*;

    localparam int unsigned MSB_WIDTH   = $clog2(ACC_WIDTH);
    localparam int unsigned E_TMP_WIDTH = ((EXP_WIDTH > MSB_WIDTH) ? EXP_WIDTH : MSB_WIDTH) + 2;

    // One output lane as a small float.
    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [SIG_WIDTH-1:0] frac;
    } fp_lane_t;

    // Per-lane state held between stage 1 and stage 2.
    typedef struct packed {
        logic                 sign;
        logic                 zero;
        logic [MSB_WIDTH-1:0] msb;
        logic [ACC_WIDTH-1:0] mag;
    } s1_lane_t;

endpackage

// File: rtl/fp_pkg.sv
// Shared small-float / block-floating-point definitions used by the
// alignment front end and the block normalizer.
package fp_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned EXP_WIDTH = 3;
    localparam int unsigned SIG_WIDTH = 4;
    localparam int unsigned ACC_WIDTH = 8;
    localparam int unsigned ALIGN     = ACC_WIDTH - 2;
    localparam int unsigned FP_WIDTH  = 1 + EXP_WIDTH + SIG_WIDTH;

    // Low bit of lane `lane` inside the packed accumulator bus.
    function automatic int unsigned acc_lo(input int unsigned lane);
        return lane * ACC_WIDTH;
    endfunction

    // Low bit of lane `lane` inside the packed {sign, exp, frac} bus.
    function automatic int unsigned fp_lo(input int unsigned lane);
        return lane * FP_WIDTH;
    endfunction

endpackage

// File: rtl/block_normalizer_if.sv
// Input and output streams of the block normalizer.
// master = the surrounding datapath (producer of inputs, consumer of results);
// slave  = the normalizer itself.
interface block_normalizer_if;

    import fp_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [EXP_WIDTH-1:0]           shared_exp;
    logic [NUM_LANES*ACC_WIDTH-1:0] in_acc;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_LANES*FP_WIDTH-1:0]  out_fp;
    logic [NUM_LANES-1:0]           ovf;
    logic [NUM_LANES-1:0]           uf;

    modport master (
        output in_valid, shared_exp, in_acc, out_ready,
        input  in_ready, out_valid, out_fp, ovf, uf
    );

    modport slave (
        input  in_valid, shared_exp, in_acc, out_ready,
        output in_ready, out_valid, out_fp, ovf, uf
    );

endinterface

// File: rtl/lead_one_detect.sv
// Leading-one position of an unsigned magnitude, plus an all-zero flag.
module lead_one_detect
    import fp_pkg::*;
    import block_normalizer_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] mag,
    output logic [MSB_WIDTH-1:0] msb_c,
    output logic                 zero_c
);

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        msb_c = '0;
        for (int unsigned i = 0; i < ACC_WIDTH; i++) begin
            if (mag[i]) begin
                msb_c = MSB_WIDTH'(i);
            end
        end
    end

    assign zero_c = (mag == '0);

endmodule

// File: rtl/block_normalizer.sv
// Converts a block-floating-point vector (signed lanes + shared exponent)
// into independent {sign, exp, frac} small floats. Two-stage valid/ready
// pipeline with per-lane saturation, flush-to-zero and sticky status.
module block_normalizer
    import fp_pkg::*;
    import block_normalizer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    block_normalizer_if.slave  bus,
    input  logic               clr_status,
    output logic               ovf_sticky,
    output logic               uf_sticky
);

    localparam logic signed [E_TMP_WIDTH-1:0] E_MAX = E_TMP_WIDTH'((1 << EXP_WIDTH) - 1);
    localparam logic signed [E_TMP_WIDTH-1:0] E_MIN = E_TMP_WIDTH'(1);

    logic                 s1_valid;
    logic                 s2_valid;
    logic [EXP_WIDTH-1:0] s1_exp;
    s1_lane_t             s1_lane [NUM_LANES];
    s1_lane_t             s1_next [NUM_LANES];

    logic signed [E_TMP_WIDTH-1:0]     e_tmp   [NUM_LANES];
    logic [ACC_WIDTH+SIG_WIDTH-1:0]    aligned [NUM_LANES];
    fp_lane_t                          s2_lane [NUM_LANES];
    logic [NUM_LANES*FP_WIDTH-1:0]     out_fp_next;
    logic [NUM_LANES-1:0]              ovf_next;
    logic [NUM_LANES-1:0]              uf_next;

    logic [NUM_LANES*FP_WIDTH-1:0]     out_fp_q;
    logic [NUM_LANES-1:0]              ovf_q;
    logic [NUM_LANES-1:0]              uf_q;

    logic s2_adv_c;
    logic s1_adv_c;
    logic in_ready_c;
    logic out_hs_c;

    // Pipeline flow control; in_ready is combinational from out_ready.
    assign s2_adv_c   = !s2_valid || bus.out_ready;
    assign s1_adv_c   = s1_valid && s2_adv_c;
    assign in_ready_c = !s1_valid || s1_adv_c;
    assign out_hs_c   = s2_valid && bus.out_ready;

    // Stage 1 front end per lane: sign, magnitude, leading-one position.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH-1:0] mag;
        logic [MSB_WIDTH-1:0] msb;
        logic                 zero;

        assign acc = bus.in_acc[acc_lo(g) +: ACC_WIDTH];
        // Most negative value maps to 2^(ACC_WIDTH-1), still representable unsigned.
        assign mag = acc[ACC_WIDTH-1] ? (ACC_WIDTH'(0) - acc) : acc;

        lead_one_detect u_lod (
            .mag    (mag),
            .msb_c  (msb),
            .zero_c (zero)
        );

        assign s1_next[g] = '{sign: acc[ACC_WIDTH-1], zero: zero, msb: msb, mag: mag};
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                s1_lane[i] <= '0;
            end
        end else if (in_ready_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_exp  <= bus.shared_exp;
                s1_lane <= s1_next;
            end
        end
    end

    // Stage 2 math: exponent, fraction alignment, saturate/flush decision.
    always_comb begin
        out_fp_next = '0;
        ovf_next    = '0;
        uf_next     = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            e_tmp[i]   = E_TMP_WIDTH'(s1_exp) + E_TMP_WIDTH'(s1_lane[i].msb) - E_TMP_WIDTH'(ALIGN);
            // Leading one lands on the top bit; the fraction sits just below it,
            // with zeros shifted in from the right when the magnitude is short.
            aligned[i] = {s1_lane[i].mag, SIG_WIDTH'(0)} << (MSB_WIDTH'(ACC_WIDTH - 1) - s1_lane[i].msb);
            s2_lane[i] = '0;
            if (s1_lane[i].zero) begin
                s2_lane[i] = '0;
            end else if (e_tmp[i] > E_MAX) begin
                s2_lane[i]  = '{sign: s1_lane[i].sign, exp: '1, frac: '1};
                ovf_next[i] = 1'b1;
            end else if (e_tmp[i] < E_MIN) begin
                s2_lane[i] = '{sign: s1_lane[i].sign, exp: '0, frac: '0};
                uf_next[i] = 1'b1;
            end else begin
                s2_lane[i] = '{sign: s1_lane[i].sign,
                               exp:  e_tmp[i][EXP_WIDTH-1:0],
                               frac: aligned[i][ACC_WIDTH+SIG_WIDTH-2 -: SIG_WIDTH]};
            end
            out_fp_next[fp_lo(i) +: FP_WIDTH] = s2_lane[i];
        end
    end

    // Stage 2 register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_fp_q <= '0;
            ovf_q    <= '0;
            uf_q     <= '0;
        end else if (s2_adv_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_fp_q <= out_fp_next;
                ovf_q    <= ovf_next;
                uf_q     <= uf_next;
            end
        end
    end

    // Sticky status; a set on handshake takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            uf_sticky  <= 1'b0;
        end else begin
            if (out_hs_c && (|ovf_q)) begin
                ovf_sticky <= 1'b1;
            end else if (clr_status) begin
                ovf_sticky <= 1'b0;
            end
            if (out_hs_c && (|uf_q)) begin
                uf_sticky <= 1'b1;
            end else if (clr_status) begin
                uf_sticky <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_valid;
    assign bus.out_fp    = out_fp_q;
    assign bus.ovf       = ovf_q;
    assign bus.uf        = uf_q;

endmodule

// File: tb/tb_block_normalizer.sv
// Self-checking bench for block_normalizer: directed scenarios plus a
// randomized phase, all scored against an arithmetic reference model.
module tb_block_normalizer;

    import fp_pkg::*;

    localparam int unsigned ACC_BUS = NUM_LANES * ACC_WIDTH;
    localparam int unsigned FP_BUS  = NUM_LANES * FP_WIDTH;

    typedef struct {
        logic [FP_BUS-1:0]    fp;
        logic [NUM_LANES-1:0] ovf;
        logic [NUM_LANES-1:0] uf;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    logic clr_status;
    logic ovf_sticky;
    logic uf_sticky;

    block_normalizer_if bus ();

    block_normalizer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .clr_status (clr_status),
        .ovf_sticky (ovf_sticky),
        .uf_sticky  (uf_sticky)
    );

    always #5 clk = ~clk;

    result_t sb[$];
    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    logic m_ovf_sticky = 1'b0;
    logic m_uf_sticky  = 1'b0;

    logic                 seen_in_ready;
    logic                 seen_out_valid;
    logic [FP_BUS-1:0]    seen_fp;
    logic [NUM_LANES-1:0] seen_ovf;
    logic [NUM_LANES-1:0] seen_uf;
    logic                 seen_ovf_sticky;
    logic                 seen_uf_sticky;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on each lane value.
    function automatic result_t model(input logic [EXP_WIDTH-1:0] se, input logic [ACC_BUS-1:0] acc);
        result_t r;
        r.fp  = '0;
        r.ovf = '0;
        r.uf  = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            logic [ACC_WIDTH-1:0] a;
            logic [FP_WIDTH-1:0]  lane;
            logic                 sgn;
            int v;
            int mag;
            int msb;
            int e;
            int frac;
            a    = acc[i*ACC_WIDTH +: ACC_WIDTH];
            v    = int'($signed(a));
            sgn  = (v < 0);
            mag  = sgn ? -v : v;
            lane = '0;
            if (mag != 0) begin
                msb = 0;
                while ((mag >> (msb + 1)) != 0) msb++;
                e    = int'(se) + msb - int'(ALIGN);
                frac = ((mag << SIG_WIDTH) >> msb) % (1 << SIG_WIDTH);
                if (e > (1 << EXP_WIDTH) - 1) begin
                    lane     = {sgn, {(EXP_WIDTH+SIG_WIDTH){1'b1}}};
                    r.ovf[i] = 1'b1;
                end else if (e < 1) begin
                    lane    = {sgn, {(EXP_WIDTH+SIG_WIDTH){1'b0}}};
                    r.uf[i] = 1'b1;
                end else begin
                    lane = {sgn, EXP_WIDTH'(e), SIG_WIDTH'(frac)};
                end
            end
            r.fp[i*FP_WIDTH +: FP_WIDTH] = lane;
        end
        return r;
    endfunction

    // Random lanes biased toward zero, most-negative, most-positive and one.
    function automatic logic [ACC_BUS-1:0] rand_acc();
        logic [ACC_BUS-1:0] a;
        a = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            case ($urandom_range(0, 7))
                0:       a[i*ACC_WIDTH +: ACC_WIDTH] = '0;
                1:       a[i*ACC_WIDTH +: ACC_WIDTH] = {1'b1, {(ACC_WIDTH-1){1'b0}}};
                2:       a[i*ACC_WIDTH +: ACC_WIDTH] = {1'b0, {(ACC_WIDTH-1){1'b1}}};
                3:       a[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(1);
                default: a[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($urandom());
            endcase
        end
        return a;
    endfunction

    // Observe the DUT just before the clock edge and update the scoreboard.
    task automatic sample();
        result_t r;
        logic    set_o;
        logic    set_u;
        set_o           = 1'b0;
        set_u           = 1'b0;
        seen_in_ready   = bus.in_ready;
        seen_out_valid  = bus.out_valid;
        seen_fp         = bus.out_fp;
        seen_ovf        = bus.ovf;
        seen_uf         = bus.uf;
        seen_ovf_sticky = ovf_sticky;
        seen_uf_sticky  = uf_sticky;
        check("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf_sticky));
        check("uf_sticky", 64'(uf_sticky), 64'(m_uf_sticky));
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(bus.out_valid), 64'(0));
            end else begin
                check("out_fp", 64'(bus.out_fp), 64'(sb[0].fp));
                check("out_ovf", 64'(bus.ovf), 64'(sb[0].ovf));
                check("out_uf", 64'(bus.uf), 64'(sb[0].uf));
                if (bus.out_ready) begin
                    r     = sb.pop_front();
                    set_o = |r.ovf;
                    set_u = |r.uf;
                    n_out++;
                end
            end
        end
        m_ovf_sticky = set_o ? 1'b1 : (clr_status ? 1'b0 : m_ovf_sticky);
        m_uf_sticky  = set_u ? 1'b1 : (clr_status ? 1'b0 : m_uf_sticky);
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.shared_exp, bus.in_acc));
            n_vec++;
        end
    endtask

    // One clock cycle: drive at the falling edge, sample, cross the rising edge.
    task automatic step(input logic iv, input logic [EXP_WIDTH-1:0] se, input logic [ACC_BUS-1:0] acc,
                        input logic ordy, input logic clr);
        bus.in_valid   = iv;
        bus.shared_exp = se;
        bus.in_acc     = acc;
        bus.out_ready  = ordy;
        clr_status     = clr;
        #1;
        sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input logic clr);
        step(1'b0, '0, '0, ordy, clr);
    endtask

    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clr_status    = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_fp", 64'(bus.out_fp), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(0));
        check("rst_uf", 64'(bus.uf), 64'(0));
        check("rst_ovf_sticky", 64'(ovf_sticky), 64'(0));
        check("rst_uf_sticky", 64'(uf_sticky), 64'(0));
        sb.delete();
        m_ovf_sticky = 1'b0;
        m_uf_sticky  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [ACC_BUS-1:0] va;
        logic [ACC_BUS-1:0] vb;
        logic [ACC_BUS-1:0] vc;
        int base;

        bus.shared_exp = '0;
        bus.in_acc     = '0;
        apply_reset();

        // Basic: lanes {64, -96, 0, 3} with shared_exp 3.
        step(1'b1, 3'd3, {8'd3, 8'd0, 8'hA0, 8'd64}, 1'b1, 1'b0);
        check("basic_accept", 64'(seen_in_ready), 64'(1));
        idle(1'b1, 1'b0);
        check("basic_lat1", 64'(seen_out_valid), 64'(0));
        idle(1'b1, 1'b0);
        check("basic_lat2", 64'(seen_out_valid), 64'(1));
        check("basic_fp", 64'(seen_fp), 64'(32'h0000_B830));
        check("basic_uf", 64'(seen_uf), 64'(4'b1000));
        check("basic_ovf", 64'(seen_ovf), 64'(0));

        // Overflow: -128 with shared_exp 7 saturates, then a lone clear.
        step(1'b1, 3'd7, {24'd0, 8'h80}, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("ovf_fp", 64'(seen_fp), 64'(32'h0000_00FF));
        check("ovf_flag", 64'(seen_ovf), 64'(4'b0001));
        idle(1'b1, 1'b0);
        check("ovf_sticky_set", 64'(seen_ovf_sticky), 64'(1));
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        check("ovf_sticky_clr", 64'(seen_ovf_sticky), 64'(0));

        // Backpressure: only two vectors fit while the consumer stalls.
        va = rand_acc();
        vb = rand_acc();
        vc = rand_acc();
        base = n_out;
        step(1'b1, 3'd4, va, 1'b0, 1'b0);
        check("bp_acc0", 64'(seen_in_ready), 64'(1));
        step(1'b1, 3'd5, vb, 1'b0, 1'b0);
        check("bp_acc1", 64'(seen_in_ready), 64'(1));
        step(1'b1, 3'd6, vc, 1'b0, 1'b0);
        check("bp_full", 64'(seen_in_ready), 64'(0));
        step(1'b1, 3'd6, vc, 1'b0, 1'b0);
        check("bp_full_hold", 64'(seen_in_ready), 64'(0));
        step(1'b1, 3'd6, vc, 1'b1, 1'b0);
        check("bp_release", 64'(seen_in_ready), 64'(1));
        for (int k = 0; k < 4; k++) idle(1'b1, 1'b0);
        check("bp_count", 64'(n_out - base), 64'(3));
        check("bp_drained", 64'(sb.size()), 64'(0));

        // Streaming: 16 back-to-back vectors, results from the third cycle on.
        base = n_out;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, EXP_WIDTH'($urandom_range(0, 7)), rand_acc(), 1'b1, 1'b0);
            check("stream_in_ready", 64'(seen_in_ready), 64'(1));
            if (k >= 2) check("stream_out_valid", 64'(seen_out_valid), 64'(1));
        end
        idle(1'b1, 1'b0);
        check("stream_tail0", 64'(seen_out_valid), 64'(1));
        idle(1'b1, 1'b0);
        check("stream_tail1", 64'(seen_out_valid), 64'(1));
        idle(1'b1, 1'b0);
        check("stream_done", 64'(seen_out_valid), 64'(0));
        check("stream_count", 64'(n_out - base), 64'(16));

        // Set/clear collision: uf handshake and clr_status in the same cycle.
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        step(1'b1, 3'd0, {16'd0, 8'd1, 8'd0}, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("coll_waiting", 64'(seen_out_valid), 64'(1));
        check("coll_pre", 64'(seen_uf_sticky), 64'(0));
        check("coll_uf1", 64'(seen_uf), 64'(4'b0010));
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        check("coll_set_wins", 64'(seen_uf_sticky), 64'(1));

        // Reset with both stages full and sticky flags set.
        step(1'b1, 3'd7, {24'd0, 8'h80}, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        step(1'b1, 3'd2, rand_acc(), 1'b0, 1'b0);
        step(1'b1, 3'd3, rand_acc(), 1'b0, 1'b0);
        check("mid_ovf_sticky", 64'(seen_ovf_sticky), 64'(1));
        check("mid_uf_sticky", 64'(seen_uf_sticky), 64'(1));
        apply_reset();
        idle(1'b1, 1'b0);
        check("post_rst_empty0", 64'(seen_out_valid), 64'(0));
        idle(1'b1, 1'b0);
        check("post_rst_empty1", 64'(seen_out_valid), 64'(0));

        // Randomized traffic with random stalls and occasional clears.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), EXP_WIDTH'($urandom_range(0, 7)), rand_acc(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int k = 0; k < 20; k++) begin
            if (sb.size() != 0) idle(1'b1, 1'b0);
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        idle(1'b1, 1'b0);
        check("drain_idle", 64'(seen_out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
